// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: FSM state encoding and default data width.
package alu_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_EXEC   = 2'd2,
    S_SHOW   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_operand_sequencer_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability-counter debouncer and
// single-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= 2'b00;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      if (sync[1] != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures two operands from the switches on LOAD presses, presents them to the
// ALU, and latches the settled result for display; CLEAR returns to idle.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = alu_seq_pkg::DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  input  logic             btn_load_i,
  input  logic             btn_clear_i,
  input  logic [WIDTH-1:0] res_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic [1:0]       state_o
);

  logic [1:0] rst_sync;
  logic       rst_int;
  logic       load_p;
  logic       clear_p;

  seq_state_t state;
  seq_state_t next_state;

  logic load_a_en;
  logic load_b_en;
  logic capture_en;
  logic clear_en;

  // Reset asserts immediately but releases two clocks after rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_int = rst_sync[1];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_load_debounce (
    .clk  (clk),
    .rst  (rst_int),
    .btn  (btn_load_i),
    .pulse(load_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_debounce (
    .clk  (clk),
    .rst  (rst_int),
    .btn  (btn_clear_i),
    .pulse(clear_p)
  );

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state <= S_LOAD_A;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clear_p) begin
      next_state = S_LOAD_A;
    end else begin
      case (state)
        S_LOAD_A: if (load_p) next_state = S_LOAD_B;
        S_LOAD_B: if (load_p) next_state = S_EXEC;
        S_EXEC:   next_state = S_SHOW;
        S_SHOW:   if (load_p) next_state = S_LOAD_B;
        default:  next_state = S_LOAD_A;
      endcase
    end
  end

  // S_EXEC gives the ALU one full cycle to settle before the result is captured.
  always_comb begin
    load_a_en  = 1'b0;
    load_b_en  = 1'b0;
    capture_en = 1'b0;
    clear_en   = clear_p;
    if (!clear_p) begin
      case (state)
        S_LOAD_A: load_a_en  = load_p;
        S_LOAD_B: load_b_en  = load_p;
        S_EXEC:   capture_en = 1'b1;
        S_SHOW:   load_a_en  = load_p;
        default:  load_a_en  = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      a_o            <= '0;
      b_o            <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else if (clear_en) begin
      a_o            <= '0;
      b_o            <= '0;
      result_o       <= '0;
      result_valid_o <= 1'b0;
    end else begin
      if (load_a_en) begin
        a_o            <= sw_i;
        result_valid_o <= 1'b0;
      end
      if (load_b_en) begin
        b_o <= sw_i;
      end
      if (capture_en) begin
        result_o       <= res_i;
        result_valid_o <= 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed self-checking bench for alu_operand_sequencer driving a 4-bit AND unit.
module tb_alu_operand_sequencer;

  localparam int W  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic         btn_load;
  logic         btn_clear;
  logic [W-1:0] res;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         valid;
  logic [1:0]   state;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign res = a & b;

  alu_operand_sequencer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_i          (sw),
    .btn_load_i    (btn_load),
    .btn_clear_i   (btn_clear),
    .res_i         (res),
    .a_o           (a),
    .b_o           (b),
    .result_o      (result),
    .result_valid_o(valid),
    .state_o       (state)
  );

  task automatic press_load(input logic [W-1:0] v);
    sw = v;
    btn_load = 1'b1;
    repeat (15) @(negedge clk);
    btn_load = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = '0; btn_load = 1'b0; btn_clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (a !== 4'b0000)    begin fails++; $display("FAIL reset_a: got %b expected 0000", a); end
    checks++; if (b !== 4'b0000)    begin fails++; $display("FAIL reset_b: got %b expected 0000", b); end
    checks++; if (result !== 4'b0000) begin fails++; $display("FAIL reset_result: got %b expected 0000", result); end
    checks++; if (valid !== 1'b0)   begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (state !== 2'd0)   begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
  endtask

  task automatic test_basic_op();
    int pulse_cyc = -1;
    int exec_first = -1;
    int exec_cnt = 0;
    logic [W-1:0] res_seen = 'x;
    logic valid_seen = 1'bx;
    logic [1:0] state_seen = 'x;
    press_load(4'b1100);
    checks++; if (a !== 4'b1100) begin fails++; $display("FAIL op_a: got %b expected 1100", a); end
    checks++; if (state !== 2'd1) begin fails++; $display("FAIL op_state_b: got %0d expected 1", state); end
    sw = 4'b1010;
    btn_load = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dut.load_p && pulse_cyc < 0) pulse_cyc = c;
      if (state == 2'd2) begin
        exec_cnt++;
        if (exec_first < 0) exec_first = c;
        if (valid !== 1'b0) begin checks++; fails++; $display("FAIL exec_valid: got %b expected 0", valid); end
      end
      if (pulse_cyc >= 0 && c == pulse_cyc + 2) begin
        res_seen = result; valid_seen = valid; state_seen = state;
      end
    end
    btn_load = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (pulse_cyc < 0) begin fails++; $display("FAIL op_pulse: got none expected one load pulse"); end
    checks++; if (exec_cnt !== 1) begin fails++; $display("FAIL exec_len: got %0d expected 1 cycle", exec_cnt); end
    checks++; if (exec_first !== pulse_cyc + 1) begin fails++; $display("FAIL exec_timing: got cycle %0d expected %0d", exec_first, pulse_cyc + 1); end
    checks++; if (b !== 4'b1010) begin fails++; $display("FAIL op_b: got %b expected 1010", b); end
    checks++; if (res_seen !== 4'b1000) begin fails++; $display("FAIL op_result: got %b expected 1000", res_seen); end
    checks++; if (valid_seen !== 1'b1) begin fails++; $display("FAIL op_valid: got %b expected 1", valid_seen); end
    checks++; if (state_seen !== 2'd3) begin fails++; $display("FAIL op_state_show: got %0d expected 3", state_seen); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    sw = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      btn_load = (c % 2 == 0);
      @(negedge clk);
      if (dut.load_p) pulses++;
    end
    btn_load = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dut.load_p) pulses++;
    end
    btn_load = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (dut.load_p) pulses++;
    end
    checks++; if (pulses !== 1) begin fails++; $display("FAIL bounce_pulses: got %0d expected 1", pulses); end
    checks++; if (a !== 4'b0011) begin fails++; $display("FAIL bounce_a: got %b expected 0011", a); end
    checks++; if (b !== 4'b1010) begin fails++; $display("FAIL bounce_b: got %b expected 1010", b); end
    checks++; if (state !== 2'd1) begin fails++; $display("FAIL bounce_state: got %0d expected 1", state); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL bounce_valid: got %b expected 0", valid); end
  endtask

  task automatic test_show_reload();
    bit seen = 0;
    btn_clear = 1'b1;
    repeat (15) @(negedge clk);
    btn_clear = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (state !== 2'd0 || a !== 4'b0000) begin fails++; $display("FAIL clear_idle: got state %0d a %b expected 0 0000", state, a); end
    press_load(4'b1100);
    press_load(4'b1010);
    checks++; if (result !== 4'b1000 || valid !== 1'b1) begin fails++; $display("FAIL show_setup: got %b/%b expected 1000/1", result, valid); end
    sw = 4'b1111;
    btn_load = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (dut.load_p) seen = 1;
    end
    checks++; if (!seen) begin fails++; $display("FAIL reload_pulse: got none expected one load pulse"); end
    @(negedge clk);
    checks++; if (a !== 4'b1111) begin fails++; $display("FAIL reload_a: got %b expected 1111", a); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reload_valid: got %b expected 0", valid); end
    checks++; if (state !== 2'd1) begin fails++; $display("FAIL reload_state: got %0d expected 1", state); end
    checks++; if (result !== 4'b1000) begin fails++; $display("FAIL reload_hold: got %b expected 1000", result); end
    repeat (12) @(negedge clk);
    btn_load = 1'b0;
    repeat (15) @(negedge clk);
    press_load(4'b0101);
    checks++; if (result !== 4'b0101) begin fails++; $display("FAIL reload_result: got %b expected 0101", result); end
    checks++; if (valid !== 1'b1 || state !== 2'd3) begin fails++; $display("FAIL reload_show: got %b/%0d expected 1/3", valid, state); end
  endtask

  task automatic test_clear_priority();
    bit both = 0;
    press_load(4'b0110);
    checks++; if (state !== 2'd1 || a !== 4'b0110) begin fails++; $display("FAIL prio_setup: got %0d/%b expected 1/0110", state, a); end
    sw = 4'b1001;
    btn_load = 1'b1;
    btn_clear = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (dut.load_p && dut.clear_p) both = 1;
    end
    btn_load = 1'b0;
    btn_clear = 1'b0;
    repeat (15) @(negedge clk);
    checks++; if (!both) begin fails++; $display("FAIL prio_coincide: got separate pulses expected same cycle"); end
    checks++; if (state !== 2'd0) begin fails++; $display("FAIL prio_state: got %0d expected 0", state); end
    checks++; if (a !== 4'b0000 || b !== 4'b0000) begin fails++; $display("FAIL prio_ops: got %b/%b expected 0000/0000", a, b); end
    checks++; if (result !== 4'b0000 || valid !== 1'b0) begin fails++; $display("FAIL prio_result: got %b/%b expected 0000/0", result, valid); end
  endtask

  task automatic test_async_reset();
    bit in_exec = 0;
    press_load(4'b1111);
    sw = 4'b0000;
    btn_load = 1'b1;
    for (int c = 0; c < 40 && !in_exec; c++) begin
      @(negedge clk);
      if (state == 2'd2) in_exec = 1;
    end
    checks++; if (!in_exec) begin fails++; $display("FAIL areset_exec: got state %0d expected to reach 2", state); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a !== 4'b0000 || b !== 4'b0000) begin fails++; $display("FAIL areset_ops: got %b/%b expected 0000/0000", a, b); end
    checks++; if (state !== 2'd0 || valid !== 1'b0) begin fails++; $display("FAIL areset_state: got %0d/%b expected 0/0", state, valid); end
    btn_load = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    press_load(4'b1111);
    press_load(4'b0000);
    checks++; if (result !== 4'b0000 || valid !== 1'b1) begin fails++; $display("FAIL areset_result: got %b/%b expected 0000/1", result, valid); end
    checks++; if (a !== 4'b1111 || state !== 2'd3) begin fails++; $display("FAIL areset_seq: got %b/%0d expected 1111/3", a, state); end
  endtask

  initial begin
    test_reset();
    test_basic_op();
    test_bounce();
    test_show_reload();
    test_clear_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
